// File: rtl/rtc_arbiter.sv
// rtc_arbiter
// Two-requester round-robin arbiter in front of a single DS1302 RTC engine.
// A granted request is latched (command + write data), issued to the engine
// with a one-cycle rtc_ena pulse, and completed with a one-cycle ackN pulse
// carrying the engine's read data.
//
// Optional feature: define RTC_ARB_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYCLES cycles in WAIT. The requester then gets rN = 8'hFF and
// timeout_err is set. Without the macro, WAIT has no time limit and
// timeout_err is tied low.
//
// Ports
//   clk               rising-edge system clock
//   clrn              synchronous active-low reset
//   req0/req1         transaction requests (held until ack)
//   addr0/addr1       DS1302 command/address byte per requester
//   w0/w1             write data per requester
//   ack0/ack1         one-cycle completion pulse per requester
//   r0/r1             read data, held until the next ack to that requester
//   rtc_addr/rtc_w    command and data driven to the engine
//   rtc_ena           one-cycle start pulse to the engine
//   rtc_r             engine read data
//   rtc_done          one-cycle completion pulse from the engine
//   busy              high whenever the arbiter is not IDLE
//   owner             current or last granted requester
//   timeout_err       sticky timeout flag
module rtc_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] w0,
    input  logic [7:0] w1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] rtc_addr,
    output logic [7:0] rtc_w,
    output logic       rtc_ena,
    input  logic [7:0] rtc_r,
    input  logic       rtc_done,
    output logic       busy,
    output logic       owner,
    output logic       timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rtc_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_owner;
    logic [7:0] r_addr;
    logic [7:0] r_w;
    logic [7:0] r_r0;
    logic [7:0] r_r1;
    logic       w_any;
    logic       w_gnt;
    logic       w_to;
    logic       w_fin;
    logic [7:0] w_rdata;

    // On a tie the requester that did not own the last grant wins; a lone
    // request wins regardless of history.
    assign w_any = req0 | req1;
    assign w_gnt = (req0 & req1) ? ~r_owner : req1;

    // WAIT ends either on the engine's done or on a timeout; a timeout
    // returns all-ones as read data.
    assign w_fin   = (r_state == WAIT) && (rtc_done || w_to);
    assign w_rdata = rtc_done ? rtc_r : 8'hFF;

`ifdef RTC_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_terr;

    // r_cnt holds the number of WAIT cycles already completed, so it reads
    // TIMEOUT_CYCLES-1 during the last permitted WAIT cycle.
    assign w_to = (r_state == WAIT) && !rtc_done &&
                  (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_cnt  <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
            else                 r_cnt <= '0;
            if (r_state == WAIT) begin
                if (rtc_done)  r_terr <= 1'b0;
                else if (w_to) r_terr <= 1'b1;
            end
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_to        = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (rtc_done || w_to) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant-time capture of command/data; later changes on addrN/wN are
    // ignored until the next grant.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_owner <= 1'b1;
            r_addr  <= 8'h00;
            r_w     <= 8'h00;
            r_r0    <= 8'h00;
            r_r1    <= 8'h00;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_owner <= w_gnt;
                r_addr  <= w_gnt ? addr1 : addr0;
                r_w     <= w_gnt ? w1 : w0;
            end
            if (w_fin) begin
                if (r_owner) r_r1 <= w_rdata;
                else         r_r0 <= w_rdata;
            end
        end
    end

    assign rtc_ena  = (r_state == ISSUE);
    assign ack0     = (r_state == ACK) && !r_owner;
    assign ack1     = (r_state == ACK) && r_owner;
    assign busy     = (r_state != IDLE);
    assign owner    = r_owner;
    assign rtc_addr = r_addr;
    assign rtc_w    = r_w;
    assign r0       = r_r0;
    assign r1       = r_r1;

endmodule

// File: tb/tb_rtc_arbiter.sv
// Self-checking bench for rtc_arbiter. The bench plays both requesters and
// the DS1302 engine; a transaction-level model (pending requests, last
// winner, last read data per requester) predicts grants and results.
module tb_rtc_arbiter;

    logic       clk = 1'b0;
    logic       clrn;
    logic       req0, req1;
    logic [7:0] addr0, addr1, w0, w1;
    logic       ack0, ack1;
    logic [7:0] r0, r1;
    logic [7:0] rtc_addr, rtc_w;
    logic       rtc_ena;
    logic [7:0] rtc_r;
    logic       rtc_done;
    logic       busy, owner, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    int         m_last;
    logic [7:0] m_r [2];

    always #5 clk = ~clk;

    rtc_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .clrn(clrn),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .w0(w0), .w1(w1),
        .ack0(ack0), .ack1(ack1),
        .r0(r0), .r1(r1),
        .rtc_addr(rtc_addr), .rtc_w(rtc_w),
        .rtc_ena(rtc_ena), .rtc_r(rtc_r), .rtc_done(rtc_done),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".ena"},   32'(rtc_ena), 0);
        chk({tag, ".acks"},  32'({ack1, ack0}), 0);
        chk({tag, ".owner"}, 32'(owner), 1);
        chk({tag, ".addr"},  32'(rtc_addr), 0);
        chk({tag, ".w"},     32'(rtc_w), 0);
        chk({tag, ".r0r1"},  32'({r1, r0}), 0);
        chk({tag, ".terr"},  32'(timeout_err), 0);
    endtask

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] w);
        if (i == 0) begin req0 = 1'b1; addr0 = a; w0 = w; end
        else        begin req1 = 1'b1; addr1 = a; w1 = w; end
    endtask

    // Called at a negedge in IDLE with requests on the ports. Runs one full
    // transaction, with dly extra WAIT cycles before done.
    task automatic txn(input int dly, input logic [7:0] rd, input bit spur);
        int g;
        logic [7:0] ea, ew;
        if (req0 && req1) g = 1 - m_last;
        else              g = req1 ? 1 : 0;
        ea = g ? addr1 : addr0;
        ew = g ? w1 : w0;
        @(negedge clk);                       // ISSUE
        chk("issue.ena",   32'(rtc_ena), 1);
        chk("issue.addr",  32'(rtc_addr), 32'(ea));
        chk("issue.w",     32'(rtc_w), 32'(ew));
        chk("issue.owner", 32'(owner), 32'(g));
        chk("issue.busy",  32'(busy), 1);
        m_last = g;
        rtc_done = spur;                      // must be ignored in ISSUE
        rtc_r = 8'h00;
        addr0 = 8'($urandom); addr1 = 8'($urandom);
        w0 = 8'($urandom);    w1 = 8'($urandom);
        @(negedge clk);                       // first WAIT cycle
        rtc_done = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("wait.ena",  32'(rtc_ena), 0);
            chk("wait.acks", 32'({ack1, ack0}), 0);
            chk("wait.addr", 32'(rtc_addr), 32'(ea));
            chk("wait.w",    32'(rtc_w), 32'(ew));
            @(negedge clk);
        end
        chk("wait.busy", 32'(busy), 1);
        chk("wait.acks", 32'({ack1, ack0}), 0);
        rtc_done = 1'b1;
        rtc_r = rd;
        @(negedge clk);                       // ACK
        m_r[g] = rd;
        chk("ack.acks",  32'({ack1, ack0}), g ? 32'd2 : 32'd1);
        chk("ack.rdata", 32'(g ? r1 : r0), 32'(rd));
        chk("ack.addr",  32'(rtc_addr), 32'(ea));
        chk("ack.ena",   32'(rtc_ena), 0);
        chk("ack.terr",  32'(timeout_err), 0);
        rtc_done = 1'b0;
        if (g == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);                       // IDLE
        chk("idle.busy", 32'(busy), 0);
        chk("idle.acks", 32'({ack1, ack0}), 0);
        chk("idle.r0",   32'(r0), 32'(m_r[0]));
        chk("idle.r1",   32'(r1), 32'(m_r[1]));
    endtask

    initial begin
        clrn = 1'b0; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; w0 = 0; w1 = 0;
        rtc_r = 0; rtc_done = 0;
        m_last = 1; m_r[0] = 0; m_r[1] = 0;
        @(negedge clk); @(negedge clk);
        chk_reset_vals("reset");
        clrn = 1'b1;
        @(negedge clk);

        // Single read: req at cycle 0, done at cycle 20, ack at 21.
        raise(0, 8'h81, 8'h00);
        txn(18, 8'h59, 1'b0);

        // First tie after a fresh reset: requester 0 first.
        clrn = 1'b0; @(negedge clk); clrn = 1'b1;
        m_last = 1; m_r[0] = 0; m_r[1] = 0;
        @(negedge clk);
        raise(0, 8'h83, 8'h11);
        raise(1, 8'h85, 8'h22);
        txn(2, 8'h12, 1'b0);
        chk("tie.first", 32'(m_last), 0);
        txn(1, 8'h34, 1'b0);
        chk("tie.owner", 32'(owner), 1);

        // Back-to-back ties: grants must alternate.
        for (int k = 0; k < 4; k++) begin
            if (!req0) raise(0, 8'($urandom), 8'($urandom));
            if (!req1) raise(1, 8'($urandom), 8'($urandom));
            txn(k, 8'($urandom), 1'b0);
            chk("b2b.alt", 32'(m_last), 32'(k % 2));
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Spurious done in IDLE.
        rtc_done = 1'b1; rtc_r = 8'hA5;
        @(negedge clk);
        chk("spur.idle.busy", 32'(busy), 0);
        chk("spur.idle.acks", 32'({ack1, ack0}), 0);
        rtc_done = 1'b0;
        @(negedge clk);
        chk("spur.idle.r", 32'({r1, r0}), 32'({m_r[1], m_r[0]}));
        // Spurious done in ISSUE.
        raise(1, 8'h8F, 8'h00);
        txn(3, 8'h77, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            int pat;
            pat = int'($urandom_range(0, 3));
            if (pat[0] && !req0) raise(0, 8'($urandom), 8'($urandom));
            if (pat[1] && !req1) raise(1, 8'($urandom), 8'($urandom));
            if (!req0 && !req1) begin
                @(negedge clk);
                chk("rnd.idle.busy", 32'(busy), 0);
                chk("rnd.idle.ena",  32'(rtc_ena), 0);
            end else begin
                txn(int'($urandom_range(0, 5)), 8'($urandom), 1'($urandom));
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

`ifdef RTC_ARB_TIMEOUT_EN
        // Timeout: 16 WAIT cycles without done.
        raise(1, 8'h81, 8'h00);
        @(negedge clk);
        chk("to.ena", 32'(rtc_ena), 1);
        m_last = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to.wait.acks", 32'({ack1, ack0}), 0);
        end
        @(negedge clk);
        chk("to.ack1", 32'(ack1), 1);
        chk("to.r1",   32'(r1), 32'hFF);
        chk("to.terr", 32'(timeout_err), 1);
        m_r[1] = 8'hFF;
        req1 = 1'b0;
        @(negedge clk);
        chk("to.sticky", 32'(timeout_err), 1);
        raise(0, 8'h83, 8'h00);
        txn(2, 8'h42, 1'b0);
        chk("to.cleared", 32'(timeout_err), 0);
`else
        // No timeout: WAIT must hold indefinitely.
        raise(0, 8'h81, 8'h00);
        @(negedge clk);
        chk("nto.ena", 32'(rtc_ena), 1);
        m_last = 0;
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("nto.busy", 32'(busy), 1);
        chk("nto.acks", 32'({ack1, ack0}), 0);
        chk("nto.terr", 32'(timeout_err), 0);
        rtc_done = 1'b1; rtc_r = 8'h3C;
        @(negedge clk);
        chk("nto.ack0", 32'(ack0), 1);
        chk("nto.r0",   32'(r0), 32'h3C);
        m_r[0] = 8'h3C;
        rtc_done = 1'b0; req0 = 1'b0;
        @(negedge clk);
`endif

        // Reset in the middle of WAIT, then a late done.
        raise(1, 8'h8D, 8'h5A);
        @(negedge clk);                       // ISSUE
        @(negedge clk);                       // WAIT
        @(negedge clk);                       // WAIT
        clrn = 1'b0; req1 = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        chk_reset_vals("midrst");
        m_last = 1; m_r[0] = 0; m_r[1] = 0;
        rtc_done = 1'b1; rtc_r = 8'hEE;
        @(negedge clk);
        chk("midrst.late.acks", 32'({ack1, ack0}), 0);
        chk("midrst.late.busy", 32'(busy), 0);
        rtc_done = 1'b0;
        @(negedge clk);
        chk("midrst.after.acks", 32'({ack1, ack0}), 0);
        chk("midrst.after.r",    32'({r1, r0}), 0);
        // Tie right after reset again goes to requester 0.
        raise(0, 8'h81, 8'h01);
        raise(1, 8'h83, 8'h02);
        txn(1, 8'h66, 1'b0);
        chk("midrst.tie", 32'(m_last), 0);
        req0 = 0; req1 = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // No cycle may show both acks, and rtc_ena only ever lasts one cycle.
    logic r_ena_q = 1'b0;
    always @(negedge clk) begin
        if (ack0 && ack1) begin
            n_err++;
            $display("FAIL ack.overlap: got both acks expected at most one");
        end
        if (rtc_ena && r_ena_q) begin
            n_err++;
            $display("FAIL ena.width: got rtc_ena 2 cycles expected 1");
        end
        r_ena_q <= rtc_ena;
    end

endmodule
